f_fetch_unit: RTL and testbench
===============================

Name: f_fetch_unit

Overview:
- Fetch stage directly downstream of the next-PC select mux.
- Holds the PC register and produces PC+4, which feeds back to the mux as its sequential-path input.
- Issues one outstanding instruction-memory request at a time and loads the IF/ID pipeline register.
- Handles decode stall and branch/jump flush; the mux output is consumed only when an instruction advances or a redirect occurs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, address/PC width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_addr_nextpc  in  ADDR_W  next PC from the next-PC mux
o_addr_pc  out  ADDR_W  current PC register
o_addr_pcplus4  out  ADDR_W  PC+4, fed back to the mux
o_imem_req  out  1  fetch request valid
o_imem_addr  out  ADDR_W  fetch address, equal to o_addr_pc
i_imem_gnt  in  1  memory accepted the request this cycle
i_imem_rvalid  in  1  read data valid; no backpressure, always accepted
i_imem_rdata  in  32  instruction word
i_id_stall  in  1  decode cannot accept a new IF/ID entry
i_flush  in  1  redirect: discard in-flight and held fetches
o_ifid_valid  out  1  IF/ID entry valid
o_ifid_instr  out  32  IF/ID instruction
o_ifid_pcplus4  out  ADDR_W  PC+4 of that instruction

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, state=IDLE, discard=0, o_ifid_valid=0, o_ifid_instr=0, o_ifid_pcplus4=0, hold buffer empty, o_imem_req=0.
- o_addr_pcplus4 = PC+4, modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- States:
  - IDLE: go to REQ on the next cycle.
  - REQ: o_imem_req = !i_flush. If req && i_imem_gnt, go to WAIT. Otherwise stay.
  - WAIT: on i_imem_rvalid:
    - discard=1: drop the data, clear discard, go to REQ.
    - IF/ID loadable (!o_ifid_valid || !i_id_stall): load IF/ID with {rdata, PC+4, valid=1}, PC <= i_addr_nextpc, go to REQ.
    - Otherwise: store {rdata, PC+4} in the hold buffer, go to HOLD.
  - HOLD: when IF/ID becomes loadable, load it from the buffer, PC <= i_addr_nextpc, go to REQ.
- Best-case throughput: one instruction per 2 cycles with a 1-cycle-latency memory. No new request issues in the cycle of the response.
- IF/ID consume: if o_ifid_valid && !i_id_stall and nothing loads that cycle, o_ifid_valid clears.
- i_flush has highest priority, over stall and load:
  - o_ifid_valid cleared; hold buffer discarded; PC <= i_addr_nextpc.
  - REQ: the request is suppressed this cycle; stay in REQ with the new PC.
  - WAIT with rvalid in the same cycle: data dropped, go to REQ.
  - WAIT without rvalid: set discard.
  - HOLD: go to REQ.
- A simultaneous flush and stall is treated as a flush.
- PC changes only on an IF/ID load or a flush; it is never updated while in HOLD.

Optional Feature:
- Macro: F_FETCH_PERFCNT_EN.
- With the macro defined:
  - Extra outputs o_cnt_fetch[31:0] (IF/ID loads), o_cnt_stall[31:0] (cycles in HOLD, or o_ifid_valid && i_id_stall), o_cnt_flush[31:0] (cycles with i_flush=1).
  - Counters reset to 0 and wrap at 2^32.
- Without the macro: these ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package f_fetch_pkg: state enum {IDLE, REQ, WAIT, HOLD}, INSTR_W=32, PC_INC=4, NOP constant 32'h0.
- Optional sub-module f_fetch_perfcnt: three-counter bank instantiated only under F_FETCH_PERFCNT_EN.
- The core FSM and IF/ID logic stay in f_fetch_unit.

Test Plan:
- Reset, then gnt/rvalid with 1-cycle latency and nextpc=pcplus4 -> imem_addr sequence 0,4,8; IF/ID pcplus4 values 4,8,C; o_ifid_valid pulses every 2 cycles.
- i_id_stall=1 while a response returns -> state HOLD, PC frozen, o_ifid_instr unchanged; drop stall -> buffered word appears in IF/ID the next cycle, PC <= nextpc.
- i_flush in WAIT with nextpc=32'h100, rvalid 2 cycles later -> response dropped, o_ifid_valid=0, next request address 32'h100.
- i_flush with i_id_stall=1 and o_ifid_valid=1 -> o_ifid_valid=0 next cycle, PC=nextpc.
- RESET_PC=32'hFFFF_FFFC -> o_addr_pcplus4=0, first fetch at 32'hFFFF_FFFC; assert i_rst_n=0 mid-WAIT -> all outputs reset immediately; a late rvalid after release is ignored (state IDLE).
- With F_FETCH_PERFCNT_EN: 3 fetches, 2 stall cycles, 1 flush -> counters read 3/2/1.

Source files
------------

// File: rtl/f_fetch_pkg.sv
// rtl/f_fetch_pkg.sv - shared types and constants for the fetch stage
package f_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

endpackage

// File: rtl/f_fetch_perfcnt.sv
// rtl/f_fetch_perfcnt.sv - fetch/stall/flush event counters (wrap at 2^32)
module f_fetch_perfcnt (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_cnt_fetch,
  output logic [31:0] o_cnt_stall,
  output logic [31:0] o_cnt_flush
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_fetch <= 32'd0;
      o_cnt_stall <= 32'd0;
      o_cnt_flush <= 32'd0;
    end else begin
      if (i_fetch) o_cnt_fetch <= o_cnt_fetch + 32'd1;
      if (i_stall) o_cnt_stall <= o_cnt_stall + 32'd1;
      if (i_flush) o_cnt_flush <= o_cnt_flush + 32'd1;
    end
  end

endmodule

// File: rtl/f_fetch_unit.sv
// rtl/f_fetch_unit.sv - PC register, single-outstanding imem fetch FSM and IF/ID register
// Optional counters enabled by defining F_FETCH_PERFCNT_EN.
module f_fetch_unit
  import f_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [ADDR_W-1:0]  i_addr_nextpc,
  output logic [ADDR_W-1:0]  o_addr_pc,
  output logic [ADDR_W-1:0]  o_addr_pcplus4,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_id_stall,
  input  logic               i_flush,
  output logic               o_ifid_valid,
  output logic [INSTR_W-1:0] o_ifid_instr,
  output logic [ADDR_W-1:0]  o_ifid_pcplus4
`ifdef F_FETCH_PERFCNT_EN
  ,
  output logic [31:0]        o_cnt_fetch,
  output logic [31:0]        o_cnt_stall,
  output logic [31:0]        o_cnt_flush
`endif
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic               discard;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pcplus4;

  logic [ADDR_W-1:0]  pc_plus4;
  logic               ifid_loadable;
  logic               resp_load;
  logic               hold_load;
  logic               ifid_load;

  assign pc_plus4       = pc + ADDR_W'(PC_INC);
  assign o_addr_pc      = pc;
  assign o_addr_pcplus4 = pc_plus4;
  assign o_imem_addr    = pc;
  // A flush suppresses the request combinationally so the old PC never issues.
  assign o_imem_req     = (state == REQ) && !i_flush;

  assign ifid_loadable = !o_ifid_valid || !i_id_stall;
  assign resp_load     = (state == WAIT) && i_imem_rvalid && !discard && !i_flush && ifid_loadable;
  assign hold_load     = (state == HOLD) && !i_flush && ifid_loadable;
  assign ifid_load     = resp_load || hold_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      discard        <= 1'b0;
      hold_instr     <= NOP;
      hold_pcplus4   <= '0;
      o_ifid_valid   <= 1'b0;
      o_ifid_instr   <= NOP;
      o_ifid_pcplus4 <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (o_imem_req && i_imem_gnt) state <= WAIT;
        end
        WAIT: begin
          if (i_imem_rvalid) begin
            if (discard || i_flush) begin
              discard <= 1'b0;
              state   <= REQ;
            end else if (ifid_loadable) begin
              state <= REQ;
            end else begin
              hold_instr   <= i_imem_rdata;
              hold_pcplus4 <= pc_plus4;
              state        <= HOLD;
            end
          end else if (i_flush) begin
            // Response for the stale PC is still in flight; drop it on arrival.
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (i_flush || ifid_loadable) state <= REQ;
        end
        default: state <= IDLE;
      endcase

      if (i_flush) begin
        pc           <= i_addr_nextpc;
        o_ifid_valid <= 1'b0;
      end else if (resp_load) begin
        o_ifid_valid   <= 1'b1;
        o_ifid_instr   <= i_imem_rdata;
        o_ifid_pcplus4 <= pc_plus4;
        pc             <= i_addr_nextpc;
      end else if (hold_load) begin
        o_ifid_valid   <= 1'b1;
        o_ifid_instr   <= hold_instr;
        o_ifid_pcplus4 <= hold_pcplus4;
        pc             <= i_addr_nextpc;
      end else if (o_ifid_valid && !i_id_stall) begin
        o_ifid_valid <= 1'b0;
      end
    end
  end

`ifdef F_FETCH_PERFCNT_EN
  logic perf_stall;
  assign perf_stall = (state == HOLD) || (o_ifid_valid && i_id_stall);

  f_fetch_perfcnt u_perfcnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_fetch     (ifid_load),
    .i_stall     (perf_stall),
    .i_flush     (i_flush),
    .o_cnt_fetch (o_cnt_fetch),
    .o_cnt_stall (o_cnt_stall),
    .o_cnt_flush (o_cnt_flush)
  );
`endif

endmodule

// File: tb/tb_f_fetch_unit.sv
// tb/tb_f_fetch_unit.sv - self-checking bench for f_fetch_unit (F_FETCH_PERFCNT_EN optional)
module tb_f_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_addr_nextpc;
  logic        i_imem_gnt, i_imem_rvalid, i_id_stall, i_flush;
  logic [31:0] i_imem_rdata;

  logic [31:0] a_pc, a_pcp4, a_iaddr, a_ifid_instr, a_ifid_p4;
  logic        a_req, a_v;
  logic [31:0] b_pc, b_pcp4, b_iaddr, b_ifid_instr, b_ifid_p4;
  logic        b_req, b_v;
`ifdef F_FETCH_PERFCNT_EN
  logic [31:0] a_cf, a_cs, a_cl, b_cf, b_cs, b_cl;
`endif

  always #5 i_clk = ~i_clk;

  f_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr_nextpc(i_addr_nextpc),
    .o_addr_pc(a_pc), .o_addr_pcplus4(a_pcp4), .o_imem_req(a_req), .o_imem_addr(a_iaddr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_id_stall(i_id_stall), .i_flush(i_flush),
    .o_ifid_valid(a_v), .o_ifid_instr(a_ifid_instr), .o_ifid_pcplus4(a_ifid_p4)
`ifdef F_FETCH_PERFCNT_EN
    , .o_cnt_fetch(a_cf), .o_cnt_stall(a_cs), .o_cnt_flush(a_cl)
`endif
  );

  f_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr_nextpc(i_addr_nextpc),
    .o_addr_pc(b_pc), .o_addr_pcplus4(b_pcp4), .o_imem_req(b_req), .o_imem_addr(b_iaddr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_id_stall(i_id_stall), .i_flush(i_flush),
    .o_ifid_valid(b_v), .o_ifid_instr(b_ifid_instr), .o_ifid_pcplus4(b_ifid_p4)
`ifdef F_FETCH_PERFCNT_EN
    , .o_cnt_fetch(b_cf), .o_cnt_stall(b_cs), .o_cnt_flush(b_cl)
`endif
  );

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        flush;
    logic [31:0] nextpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_instr;
    logic        push;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] p4;
  } ent_t;

  localparam int NV = 28;
  vec_t tbl[NV];
  ent_t sbq[$];
  ent_t ent;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_v, prev_stall;

  function automatic vec_t mk(logic g, logic r, logic [31:0] d, logic s, logic f, logic [31:0] n,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ei, logic p);
    vec_t v;
    v = '{gnt: g, rvalid: r, rdata: d, stall: s, flush: f, nextpc: n,
          exp_req: er, exp_addr: ea, exp_v: ev, exp_instr: ei, push: p};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic r, input logic [31:0] d, input logic s,
                       input logic f, input logic [31:0] n);
    i_imem_gnt = g; i_imem_rvalid = r; i_imem_rdata = d;
    i_id_stall = s; i_flush = f; i_addr_nextpc = n;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  initial begin
    //           g  r  rdata         s  f  nextpc        req addr          v  instr         push
    tbl[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  32'h0,        0, 32'h0,        0);
    tbl[1]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  32'h0,        0, 32'h0,        0);
    tbl[2]  = mk(0, 1, 32'hA000_0000, 0, 0, 32'h4,       0,  32'h0,        0, 32'h0,        1);
    tbl[3]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  32'h4,        1, 32'hA000_0000, 0);
    tbl[4]  = mk(0, 1, 32'hA000_0001, 0, 0, 32'h8,       0,  32'h4,        0, 32'h0,        1);
    tbl[5]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  32'h8,        1, 32'hA000_0001, 0);
    tbl[6]  = mk(0, 1, 32'hA000_0002, 0, 0, 32'hC,       0,  32'h8,        0, 32'h0,        1);
    tbl[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1,  32'hC,        1, 32'hA000_0002, 0);
    tbl[8]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  32'hC,        0, 32'h0,        0);
    tbl[9]  = mk(0, 1, 32'hA000_0003, 1, 0, 32'h10,      0,  32'hC,        0, 32'h0,        1);
    tbl[10] = mk(1, 0, 32'h0,        1, 0, 32'h0,        1,  32'h10,       1, 32'hA000_0003, 0);
    tbl[11] = mk(0, 1, 32'hA000_0004, 1, 0, 32'h14,      0,  32'h10,       1, 32'hA000_0003, 1);
    tbl[12] = mk(0, 0, 32'h0,        1, 0, 32'h14,       0,  32'h10,       1, 32'hA000_0003, 0);
    tbl[13] = mk(0, 0, 32'h0,        0, 0, 32'h14,       0,  32'h10,       1, 32'hA000_0003, 0);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1,  32'h14,       1, 32'hA000_0004, 0);
    tbl[15] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  32'h14,       0, 32'h0,        0);
    tbl[16] = mk(0, 0, 32'h0,        0, 1, 32'h100,      0,  32'h14,       0, 32'h0,        0);
    tbl[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  32'h100,      0, 32'h0,        0);
    tbl[18] = mk(0, 1, 32'hDEAD_DEAD, 0, 0, 32'h0,       0,  32'h100,      0, 32'h0,        0);
    tbl[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1,  32'h100,      0, 32'h0,        0);
    tbl[20] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  32'h100,      0, 32'h0,        0);
    tbl[21] = mk(0, 1, 32'hA000_0005, 0, 0, 32'h104,     0,  32'h100,      0, 32'h0,        1);
    tbl[22] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1,  32'h104,      1, 32'hA000_0005, 0);
    tbl[23] = mk(0, 0, 32'h0,        1, 1, 32'h200,      0,  32'h104,      1, 32'hA000_0005, 0);
    tbl[24] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1,  32'h200,      0, 32'h0,        0);
    tbl[25] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1,  32'h200,      0, 32'h0,        0);
    tbl[26] = mk(0, 1, 32'hBEEF_BEEF, 0, 1, 32'h300,     0,  32'h200,      0, 32'h0,        0);
    tbl[27] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1,  32'h300,      0, 32'h0,        0);

    // Reset values
    do_reset();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("rst_req", {31'b0, a_req}, 32'h0);
    check("rst_valid", {31'b0, a_v}, 32'h0);
    check("rst_instr", a_ifid_instr, 32'h0);
    check("rst_ifid_p4", a_ifid_p4, 32'h0);
    check("rst_pc", a_pc, 32'h0);
    check("rst_pcp4", a_pcp4, 32'h4);
    check("rst_pc_hi", b_pc, 32'hFFFF_FFFC);
    check("rst_pcp4_wrap", b_pcp4, 32'h0);
    do_reset();

    // Table-driven sequence with IF/ID scoreboard
    prev_v = 1'b0;
    prev_stall = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].stall, tbl[i].flush, tbl[i].nextpc);
      if (tbl[i].push) sbq.push_back('{instr: tbl[i].rdata, p4: tbl[i].exp_addr + 32'd4});
      @(negedge i_clk);
      check($sformatf("r%0d_req", i), {31'b0, a_req}, {31'b0, tbl[i].exp_req});
      check($sformatf("r%0d_imem_addr", i), a_iaddr, tbl[i].exp_addr);
      check($sformatf("r%0d_pcp4", i), a_pcp4, tbl[i].exp_addr + 32'd4);
      check($sformatf("r%0d_valid", i), {31'b0, a_v}, {31'b0, tbl[i].exp_v});
      if (tbl[i].exp_v) check($sformatf("r%0d_instr", i), a_ifid_instr, tbl[i].exp_instr);
      if (a_v && (!prev_v || !prev_stall)) begin
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r%0d_sb: got unexpected entry %h expected none", i, a_ifid_instr);
        end else begin
          ent = sbq.pop_front();
          check($sformatf("r%0d_sb_instr", i), a_ifid_instr, ent.instr);
          check($sformatf("r%0d_sb_p4", i), a_ifid_p4, ent.p4);
        end
      end
      prev_v = a_v;
      prev_stall = i_id_stall;
      next_cycle();
    end
    check("sb_empty", sbq.size(), 32'd0);

    // High reset PC: wrap, then reset asserted mid-WAIT and a late response
    do_reset();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge i_clk);
    check("hi_idle_req", {31'b0, b_req}, 32'h0);
    next_cycle();
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge i_clk);
    check("hi_req", {31'b0, b_req}, 32'h1);
    check("hi_addr", b_iaddr, 32'hFFFF_FFFC);
    next_cycle();
    drive(0, 1, 32'h1234_5678, 0, 0, 32'h0);
    next_cycle();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    @(negedge i_clk);
    check("hi_valid", {31'b0, b_v}, 32'h1);
    check("hi_instr", b_ifid_instr, 32'h1234_5678);
    check("hi_ifid_p4_wrap", b_ifid_p4, 32'h0);
    check("hi_pc_next", b_pc, 32'h0);
    next_cycle();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, b_v}, 32'h0);
    check("arst_instr", b_ifid_instr, 32'h0);
    check("arst_ifid_p4", b_ifid_p4, 32'h0);
    check("arst_req", {31'b0, b_req}, 32'h0);
    check("arst_pc", b_pc, 32'hFFFF_FFFC);
    next_cycle();
    i_rst_n = 1'b1;
    drive(0, 1, 32'hBAD0_BAD0, 0, 0, 32'h40);
    @(negedge i_clk);
    check("late_req_idle", {31'b0, b_req}, 32'h0);
    next_cycle();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge i_clk);
    check("late_valid", {31'b0, b_v}, 32'h0);
    check("late_req", {31'b0, b_req}, 32'h1);
    check("late_addr", b_iaddr, 32'hFFFF_FFFC);
    next_cycle();

`ifdef F_FETCH_PERFCNT_EN
    do_reset();
    @(negedge i_clk);
    check("cnt_rst_fetch", a_cf, 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 0, 0, 32'h0);  next_cycle();
    drive(0, 1, 32'h11, 0, 0, 32'h4); next_cycle();
    drive(1, 0, 32'h0, 0, 0, 32'h0);  next_cycle();
    drive(0, 1, 32'h22, 0, 0, 32'h8); next_cycle();
    drive(1, 0, 32'h0, 1, 0, 32'h0);  next_cycle();
    drive(0, 0, 32'h0, 1, 0, 32'h0);  next_cycle();
    drive(0, 1, 32'h33, 0, 0, 32'hC); next_cycle();
    drive(0, 0, 32'h0, 0, 1, 32'h80); next_cycle();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge i_clk);
    check("cnt_fetch", a_cf, 32'd3);
    check("cnt_stall", a_cs, 32'd2);
    check("cnt_flush", a_cl, 32'd1);
    next_cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
